pwm_duty_ramp: RTL and testbench



---
 rtl/pwm_duty_ramp_if.sv | 28 ++
 rtl/pwm_duty_ramp.sv | 141 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_if.sv
// Command/status bundle between a controller and the PWM duty ramp.
// The controller side (master) issues ramp commands and supplies the PWM
// period; the ramp (slave) returns the duty value for the PWM block plus
// status and the period boundary marker.
interface pwm_duty_ramp_if #(
  parameter int W  = 16,
  parameter int DW = 8
);
  logic [W-1:0]  period;
  logic          start;
  logic [W-1:0]  target;
  logic [W-1:0]  step;
  logic [DW-1:0] dwell;
  logic [W-1:0]  duty_cycle;
  logic          busy;
  logic          done;
  logic          period_tick;

  modport master (
    output period, start, target, step, dwell,
    input  duty_cycle, busy, done, period_tick
  );

  modport slave (
    input  period, start, target, step, dwell,
    output duty_cycle, busy, done, period_tick
  );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp generator feeding a PWM block. A free-running period
// counter mirrors the PWM counter so that every duty change is applied on
// a whole-period boundary: the new value becomes visible in cycle 0 of the
// following period. A command strobe captures target/step/dwell; the ramp
// then moves duty by step every dwell+1 periods until it lands on target.
module pwm_duty_ramp #(
  parameter int W  = 16,
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst,
  pwm_duty_ramp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  cnt;
  logic [W-1:0]  duty, duty_n;
  logic [W-1:0]  tgt, tgt_n;
  logic [W-1:0]  stp, stp_n;
  logic [DW-1:0] dw, dw_n;
  logic [DW-1:0] dwell_cnt, dwell_cnt_n;

  logic          wrap;
  logic          tick;
  logic [W-1:0]  target_clamped;
  logic [W-1:0]  gap;

  // A period of 0 or 1 collapses the counter to a single state that is
  // always the last one. The >= test lets the counter recover at once when
  // the period is shortened below the current count.
  assign wrap = (bus.period <= W'(1)) || (cnt >= bus.period - W'(1));

  // Held low during reset so no boundary is reported while clearing.
  assign tick = wrap & ~rst;

  // A duty above the period would mean "always high"; clamp at capture.
  assign target_clamped = (bus.target > bus.period) ? bus.period : bus.target;

  // Unsigned distance to the target, used to decide the final snap.
  assign gap = (duty < tgt) ? (tgt - duty) : (duty - tgt);

  // Period counter running in lockstep with the PWM counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // Ramp state and command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      duty      <= '0;
      tgt       <= '0;
      stp       <= '0;
      dw        <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_n;
      duty      <= duty_n;
      tgt       <= tgt_n;
      stp       <= stp_n;
      dw        <= dw_n;
      dwell_cnt <= dwell_cnt_n;
    end
  end

  // Next-state logic: command capture first, then the per-period update.
  always_comb begin
    // NOTE: every output of this block gets a hold value up front, so no
    // path through the branches below can leave one unassigned (no latch).
    state_n     = state;
    duty_n      = duty;
    tgt_n       = tgt;
    stp_n       = stp;
    dw_n        = dw;
    dwell_cnt_n = dwell_cnt;

    if (bus.start) begin
      // A new command wins over any update due this cycle; duty is kept so
      // a retarget continues smoothly from wherever the ramp currently is.
      tgt_n       = target_clamped;
      stp_n       = bus.step;
      dw_n        = bus.dwell;
      dwell_cnt_n = '0;
      state_n     = RAMP;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = IDLE;
        end

        RAMP: begin
          if (tick) begin
            if (dwell_cnt == dw) begin
              dwell_cnt_n = '0;
              if ((stp == '0) || (gap <= stp)) begin
                // Final snap: also covers step=0 (jump) and the case where
                // a full step would overshoot or wrap below zero.
                duty_n  = tgt;
                state_n = DONE;
              end else if (duty < tgt) begin
                duty_n = duty + stp;
              end else begin
                duty_n = duty - stp;
              end
            end else begin
              dwell_cnt_n = dwell_cnt + DW'(1);
            end
          end
        end

        DONE: begin
          state_n = IDLE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.duty_cycle  = duty;
  assign bus.busy        = (state == RAMP);
  assign bus.done        = (state == DONE);
  assign bus.period_tick = tick;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp. Each command pushes the duty values it
// should produce (with the period-tick index at which each must appear)
// onto a scoreboard queue; a per-cycle monitor pops and compares whenever
// duty_cycle moves, and checks every done pulse against its expectation.
module tb_pwm_duty_ramp;

  localparam int W  = 16;
  localparam int DW = 8;

  typedef struct {
    logic [W-1:0] duty;
    int           ticks;
    bit           last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwm_duty_ramp_if #(.W(W), .DW(DW)) bus ();

  pwm_duty_ramp #(.W(W), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  logic [W-1:0] prev_duty = '0;
  logic         prev_tick = 1'b0;
  logic         prev_done = 1'b0;
  int           ticks_since = 0;
  int           done_count = 0;
  logic [W-1:0] exp_final = '0;
  int           exp_done_tick = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input int t, input bit l);
    exp_t e;
    e.duty  = d;
    e.ticks = t;
    e.last  = l;
    exp_q.push_back(e);
  endtask

  task automatic expect_done(input logic [W-1:0] f, input int t);
    exp_final     = f;
    exp_done_tick = t;
    done_count    = 0;
  endtask

  // One clock: sample at the falling edge and run the scoreboard.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (rst !== 1'b1) begin
      if (bus.duty_cycle !== prev_duty) begin
        check("duty_moved_after_tick", {31'b0, prev_tick}, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_duty_change", bus.duty_cycle, prev_duty);
        end else begin
          e = exp_q.pop_front();
          check("duty_value", bus.duty_cycle, e.duty);
          check("duty_tick_index", ticks_since, e.ticks);
          if (e.last) check("done_with_final_duty", bus.done, 1);
        end
      end
      if (bus.done === 1'b1) begin
        done_count++;
        check("done_busy_low", bus.busy, 0);
        check("done_duty", bus.duty_cycle, exp_final);
        check("done_tick_index", ticks_since, exp_done_tick);
        check("done_single_cycle", prev_done, 0);
      end
      if (bus.period_tick === 1'b1) ticks_since++;
    end
    prev_duty = bus.duty_cycle;
    prev_tick = bus.period_tick;
    prev_done = bus.done;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_start(input logic [W-1:0] t, input logic [W-1:0] s, input logic [DW-1:0] d);
    bus.target  = t;
    bus.step    = s;
    bus.dwell   = d;
    bus.start   = 1'b1;
    ticks_since = 0;
    cycle();
    bus.start   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    check("rst_duty", bus.duty_cycle, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tick", bus.period_tick, 0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    bus.period = 16'd10;
    bus.start  = 1'b0;
    bus.target = '0;
    bus.step   = '0;
    bus.dwell  = '0;

    // Power-on reset.
    run(2);
    do_reset();
    run(3);

    // 1: reset in the middle of a ramp; no completion may follow.
    expect_done(16'd8, 4);
    do_start(16'd8, 16'd2, 8'd0);
    push(16'd2, 1, 1'b0);
    push(16'd4, 2, 1'b0);
    push(16'd6, 3, 1'b0);
    push(16'd8, 4, 1'b1);
    run(25);
    do_reset();
    run(40);
    check("t1_no_done", done_count, 0);
    check("t1_duty_idle", bus.duty_cycle, 0);

    // 2: up-ramp 0 -> 7 in steps of 2, one update per period.
    expect_done(16'd7, 4);
    do_start(16'd7, 16'd2, 8'd0);
    push(16'd2, 1, 1'b0);
    push(16'd4, 2, 1'b0);
    push(16'd6, 3, 1'b0);
    push(16'd7, 4, 1'b1);
    run(50);
    check("t2_done_count", done_count, 1);
    check("t2_queue_drained", exp_q.size(), 0);

    // 3: down-ramp 7 -> 1 in steps of 3, updating every third period.
    expect_done(16'd1, 6);
    do_start(16'd1, 16'd3, 8'd2);
    push(16'd4, 3, 1'b0);
    push(16'd1, 6, 1'b1);
    run(75);
    check("t3_done_count", done_count, 1);
    check("t3_queue_drained", exp_q.size(), 0);

    // 4: target above a shorter period clamps and jumps (step 0), then a
    //    command equal to the current duty completes without moving it.
    bus.period = 16'd5;
    run(3);
    expect_done(16'd5, 1);
    do_start(16'd9, 16'd0, 8'd0);
    push(16'd5, 1, 1'b1);
    run(15);
    check("t4a_done_count", done_count, 1);
    check("t4a_queue_drained", exp_q.size(), 0);
    expect_done(16'd5, 1);
    do_start(16'd5, 16'd0, 8'd0);
    run(15);
    check("t4b_done_count", done_count, 1);
    check("t4b_duty_held", bus.duty_cycle, 5);

    // 5: retarget mid-ramp, then a command landing on a qualifying tick.
    bus.period = 16'd8;
    do_reset();
    expect_done(16'd8, 8);
    do_start(16'd8, 16'd1, 8'd0);
    push(16'd1, 1, 1'b0);
    push(16'd2, 2, 1'b0);
    push(16'd3, 3, 1'b0);
    push(16'd4, 4, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (bus.duty_cycle === 16'd4) break;
      cycle();
    end
    check("t5_reached_4", bus.duty_cycle, 4);
    check("t5_busy_mid", bus.busy, 1);
    expect_done(16'd2, 2);
    do_start(16'd2, 16'd1, 8'd0);
    push(16'd3, 1, 1'b0);
    push(16'd2, 2, 1'b1);
    run(30);
    check("t5a_done_count", done_count, 1);
    check("t5a_queue_drained", exp_q.size(), 0);

    done_count = 0;
    do_start(16'd6, 16'd1, 8'd0);
    for (int i = 0; i < 20; i++) begin
      if (prev_tick === 1'b1) break;
      cycle();
    end
    check("t5b_tick_found", prev_tick, 1);
    expect_done(16'd6, 2);
    do_start(16'd6, 16'd2, 8'd0);
    push(16'd4, 1, 1'b0);
    push(16'd6, 2, 1'b1);
    run(30);
    check("t5b_done_count", done_count, 1);
    check("t5b_queue_drained", exp_q.size(), 0);

    // 6: degenerate periods tick every cycle and clamp the target.
    bus.period = 16'd1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_tick_p1", bus.period_tick, 1);
    end
    expect_done(16'd1, 1);
    do_start(16'd3, 16'd1, 8'd0);
    push(16'd1, 1, 1'b1);
    run(5);
    check("t6a_done_count", done_count, 1);
    check("t6a_duty", bus.duty_cycle, 1);

    bus.period = 16'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_tick_p0", bus.period_tick, 1);
    end
    expect_done(16'd0, 1);
    do_start(16'd3, 16'd1, 8'd0);
    push(16'd0, 1, 1'b1);
    run(5);
    check("t6b_done_count", done_count, 1);
    check("t6b_duty", bus.duty_cycle, 0);
    check("t6b_queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
